// File: rtl/lbc_pkg.sv
// Shared types and sizing helpers for the line-buffer window controller.
package lbc_pkg;
  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} lbc_state_e;

  // Position counter width with one bit of headroom over the larger axis.
  function automatic int lbc_cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  function automatic int lbc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lbc_axis_counter.sv
// One raster axis: position with wrap, stride phase and window-hit flag.
// Outputs describe the pixel being accepted this cycle (clear applied first).
module lbc_axis_counter
  import lbc_pkg::*;
#(
  parameter int LEN    = 64,
  parameter int KERNEL = 3,
  parameter int STRIDE = 2,
  parameter int W      = lbc_cnt_w(LEN, LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_wrap,
  output logic o_hit
);
  logic [W-1:0] r_pos;
  logic [2:0]   r_phase;
  logic [W-1:0] w_pos;
  logic [2:0]   w_phase;

  assign w_pos   = i_clr ? '0 : r_pos;
  assign w_phase = i_clr ? '0 : r_phase;
  assign o_wrap  = (w_pos == W'(LEN - 1));
  assign o_hit   = (w_pos >= W'(KERNEL - 1)) && (w_phase == 3'd0);

  // Phase restarts at KERNEL-1 so phase==0 marks every STRIDE-th window end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos   <= '0;
      r_phase <= '0;
    end else if (i_adv) begin
      if (o_wrap) begin
        r_pos   <= '0;
        r_phase <= '0;
      end else begin
        r_pos <= w_pos + 1'b1;
        if (w_pos < W'(KERNEL - 1))          r_phase <= '0;
        else if (w_phase == 3'(STRIDE - 1))  r_phase <= '0;
        else                                 r_phase <= w_phase + 1'b1;
      end
    end else if (i_clr) begin
      r_pos   <= '0;
      r_phase <= '0;
    end
  end
endmodule

// File: rtl/line_buffer_control_generic.sv
// Sliding-window control for a raster pixel stream: flags each completed KERNELxKERNEL
// window on a STRIDE grid. Optional status ports under LBC_STATUS_EN.
module line_buffer_control_generic
  import lbc_pkg::*;
#(
  parameter int INPUT_Y = 64,
  parameter int INPUT_X = 64,
  parameter int KERNEL  = 3,
  parameter int STRIDE  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sof,
  input  logic input_valid,
  output logic output_valid
`ifdef LBC_STATUS_EN
  ,
  output logic [lbc_idx_w(INPUT_X)-1:0] out_row,
  output logic [lbc_idx_w(INPUT_Y)-1:0] out_col,
  output logic                          frame_done
`endif
);
  localparam int W = lbc_cnt_w(INPUT_X, INPUT_Y);

  lbc_state_e r_state;
  lbc_state_e w_base;
  logic       r_output_valid;
  logic       w_acc, w_last, w_pulse;
  logic       w_col_wrap, w_col_hit, w_row_wrap, w_row_hit;

  // sof restarts from any state and may itself carry pixel (0,0).
  assign w_base  = sof ? ((KERNEL == 1) ? ACTIVE : FILL) : r_state;
  assign w_acc   = input_valid && (w_base == FILL || w_base == ACTIVE);
  assign w_last  = w_row_wrap && w_col_wrap;
  assign w_pulse = w_acc && w_col_hit && w_row_hit;

  lbc_axis_counter #(.LEN(INPUT_Y), .KERNEL(KERNEL), .STRIDE(STRIDE), .W(W)) u_col (
    .clk(clk), .rst(rst), .i_clr(sof), .i_adv(w_acc),
    .o_wrap(w_col_wrap), .o_hit(w_col_hit)
  );

  lbc_axis_counter #(.LEN(INPUT_X), .KERNEL(KERNEL), .STRIDE(STRIDE), .W(W)) u_row (
    .clk(clk), .rst(rst), .i_clr(sof), .i_adv(w_acc && w_col_wrap),
    .o_wrap(w_row_wrap), .o_hit(w_row_hit)
  );

  // In FILL the first row hit at end of line is exactly pixel (KERNEL-1, INPUT_Y-1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_output_valid <= 1'b0;
    end else begin
      r_output_valid <= w_pulse;
      if (w_acc && w_last)
        r_state <= DONE;
      else if (w_acc && w_base == FILL && w_row_hit && w_col_wrap)
        r_state <= ACTIVE;
      else
        r_state <= w_base;
    end
  end

  assign output_valid = r_output_valid;

`ifdef LBC_STATUS_EN
  logic [lbc_idx_w(INPUT_X)-1:0] r_out_row;
  logic [lbc_idx_w(INPUT_Y)-1:0] r_out_col;
  logic r_frame_done, r_row_open, r_any;
  logic w_open, w_any;

  // Output indices advance per pulse in raster order; no division needed.
  assign w_open = r_row_open && !sof;
  assign w_any  = r_any && !sof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
      r_row_open   <= 1'b0;
      r_any        <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_last;
      r_row_open   <= (w_acc && w_col_wrap) ? 1'b0 : (w_pulse | w_open);
      if (w_pulse) begin
        r_any <= 1'b1;
        if (w_open) begin
          r_out_col <= r_out_col + 1'b1;
        end else begin
          r_out_col <= '0;
          r_out_row <= w_any ? r_out_row + 1'b1 : '0;
        end
      end else if (sof) begin
        r_any <= 1'b0;
      end
    end
  end

  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;
`endif
endmodule

// File: tb/tb_line_buffer_control_generic.sv
// Directed bench: 8x8 frames, K=3, with STRIDE=2 and STRIDE=1 instances on shared stimulus.
module tb_line_buffer_control_generic;
  localparam int Y = 8;
  localparam int X = 8;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst, sof, input_valid;
  logic [1:0] ov;
`ifdef LBC_STATUS_EN
  logic [2:0] orow [2];
  logic [2:0] ocol [2];
  logic [1:0] fd;
`endif

  always #5 clk = ~clk;

  line_buffer_control_generic #(.INPUT_Y(Y), .INPUT_X(X), .KERNEL(K), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .sof(sof), .input_valid(input_valid), .output_valid(ov[0])
`ifdef LBC_STATUS_EN
    , .out_row(orow[0]), .out_col(ocol[0]), .frame_done(fd[0])
`endif
  );

  line_buffer_control_generic #(.INPUT_Y(Y), .INPUT_X(X), .KERNEL(K), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .sof(sof), .input_valid(input_valid), .output_valid(ov[1])
`ifdef LBC_STATUS_EN
    , .out_row(orow[1]), .out_col(ocol[1]), .frame_done(fd[1])
`endif
  );

  typedef struct {
    int gap_pct;
    int sof_v;
    int abort_at;
    int extra;
    int exp_s2;
    int exp_s1;
  } scen_t;

  int n_chk, n_pass;
  bit m_act;
  int m_r, m_c;
  int cnt [2];
  int e_row [2];
  int e_col [2];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle, predict from a raster position model, compare after the edge.
  task automatic step(input bit s, input bit v);
    bit acc;
    bit exp_ov [2];
    bit exp_fd;
    int sv [2];
    sv[0] = 2;
    sv[1] = 1;
    sof = s;
    input_valid = v;
    if (s) begin
      m_act = 1'b1; m_r = 0; m_c = 0;
      cnt[0] = 0; cnt[1] = 0;
    end
    acc = v && m_act;
    exp_fd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_ov[d] = acc && m_r >= K-1 && m_c >= K-1 &&
                  ((m_r-K+1) % sv[d] == 0) && ((m_c-K+1) % sv[d] == 0);
      if (exp_ov[d]) begin
        e_row[d] = (m_r-K+1) / sv[d];
        e_col[d] = (m_c-K+1) / sv[d];
      end
    end
    if (acc) begin
      if (m_r == X-1 && m_c == Y-1) begin
        m_act = 1'b0;
        exp_fd = 1'b1;
      end
      if (m_c == Y-1) begin m_c = 0; m_r++; end
      else m_c++;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("output_valid[s%0d]", sv[d]), int'(ov[d]), int'(exp_ov[d]));
      if (ov[d]) cnt[d]++;
`ifdef LBC_STATUS_EN
      check($sformatf("frame_done[s%0d]", sv[d]), int'(fd[d]), int'(exp_fd));
      check($sformatf("out_row[s%0d]", sv[d]), int'(orow[d]), e_row[d]);
      check($sformatf("out_col[s%0d]", sv[d]), int'(ocol[d]), e_col[d]);
`endif
    end
  endtask

  task automatic run(input scen_t sc);
    int fed;
    bit aborted;
    aborted = 1'b0;
    step(1'b1, bit'(sc.sof_v));
    fed = sc.sof_v;
    while (fed < X*Y) begin
      if (sc.gap_pct > 0 && int'($urandom_range(0, 99)) < sc.gap_pct) begin
        step(1'b0, 1'b0);
      end else if (!aborted && sc.abort_at > 0 && fed == sc.abort_at) begin
        step(1'b1, 1'b1);
        fed = 1;
        aborted = 1'b1;
      end else begin
        step(1'b0, 1'b1);
        fed++;
      end
    end
    repeat (sc.extra) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("pulse_count_s2", cnt[0], sc.exp_s2);
    check("pulse_count_s1", cnt[1], sc.exp_s1);
  endtask

  scen_t tbl [5];

  initial begin
    tbl[0] = '{gap_pct: 0,  sof_v: 1, abort_at: 0,  extra: 0, exp_s2: 9, exp_s1: 36};
    tbl[1] = '{gap_pct: 35, sof_v: 1, abort_at: 0,  extra: 0, exp_s2: 9, exp_s1: 36};
    tbl[2] = '{gap_pct: 0,  sof_v: 1, abort_at: 30, extra: 0, exp_s2: 9, exp_s1: 36};
    tbl[3] = '{gap_pct: 0,  sof_v: 0, abort_at: 0,  extra: 6, exp_s2: 9, exp_s1: 36};
    tbl[4] = '{gap_pct: 25, sof_v: 0, abort_at: 17, extra: 4, exp_s2: 9, exp_s1: 36};

    n_chk = 0; n_pass = 0;
    m_act = 1'b0; m_r = 0; m_c = 0;
    cnt[0] = 0; cnt[1] = 0;
    e_row[0] = 0; e_row[1] = 0; e_col[0] = 0; e_col[1] = 0;
    rst = 1'b0; sof = 1'b0; input_valid = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ov_s2", int'(ov[0]), 0);
    check("reset_ov_s1", int'(ov[1]), 0);
`ifdef LBC_STATUS_EN
    check("reset_frame_done", int'(fd[0]), 0);
    check("reset_out_row", int'(orow[0]), 0);
    check("reset_out_col", int'(ocol[0]), 0);
`endif
    input_valid = 1'b0;
    rst = 1'b1;

    // Pixels before the first sof are ignored.
    repeat (24) step(1'b0, 1'b1);

    for (int i = 0; i < 5; i++) run(tbl[i]);

    // Asynchronous reset while a pulse is showing, mid-frame.
    step(1'b1, 1'b1);
    repeat (18) step(1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check("async_reset_ov_s2", int'(ov[0]), 0);
    check("async_reset_ov_s1", int'(ov[1]), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_act = 1'b0;
    e_row[0] = 0; e_row[1] = 0; e_col[0] = 0; e_col[1] = 0;
    repeat (30) step(1'b0, 1'b1);
    run(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/line_buffer_control_generic.md
LINE_BUFFER_CONTROL_GENERIC -- requirements
Module: line_buffer_control_generic

Interface
REQ-001 SHALL have parameter INPUT_Y, default 64, meaning pixels per input line.
REQ-002 SHALL have parameter INPUT_X, default 64, meaning lines per input frame.
REQ-003 SHALL have parameter KERNEL, default 3, meaning window height and width; legal range 1..7.
REQ-004 SHALL have parameter STRIDE, default 2, meaning window step in both axes; legal range 1..4.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port sof, input, 1, start-of-frame strobe.
REQ-008 SHALL have port input_valid, input, 1, one pixel accepted this cycle.
REQ-009 SHALL have port output_valid, output, 1, registered pulse: a full KERNEL x KERNEL window ends on the pixel accepted last cycle.
REQ-010 SHALL, with LBC_STATUS_EN only, have ports out_row and out_col (outputs, $clog2 of INPUT_X/INPUT_Y, window top-left output index) and frame_done (output, 1, pulse).

Function
REQ-011 SHALL track input column c (0..INPUT_Y-1) and row r (0..INPUT_X-1); c wraps to 0 and r increments on each accepted last-column pixel.
REQ-012 SHALL implement states IDLE, FILL, ACTIVE, DONE.
REQ-013 SHALL leave IDLE or DONE only on sof=1; a sof beat with input_valid=1 is pixel (0,0), and without input_valid the next accepted pixel is (0,0).
REQ-014 SHALL transition FILL->ACTIVE on the accepted pixel (KERNEL-1, INPUT_Y-1); KERNEL=1 enters ACTIVE directly.
REQ-015 SHALL assert output_valid for exactly one cycle, one cycle after accepting pixel (r,c) with r>=KERNEL-1, c>=KERNEL-1, (r-KERNEL+1)%STRIDE==0 and (c-KERNEL+1)%STRIDE==0.
REQ-016 SHALL derive the stride conditions from phase counters reset at r/c = KERNEL-1, with no divider or modulo operator.
REQ-017 SHALL hold output_valid low on any cycle with input_valid=0 in the previous cycle.
REQ-018 SHALL move ACTIVE->DONE on accepting pixel (INPUT_X-1, INPUT_Y-1) and ignore input_valid in DONE.
REQ-019 SHALL treat sof in any state, including mid-frame, as an immediate restart: counters cleared, FILL entered, no output_valid from the aborted frame on the following cycle.
REQ-020 SHALL size counters to $clog2(max(INPUT_X,INPUT_Y))+1 bits with no overflow at any legal parameter set.

Reset
REQ-021 SHALL, while rst=0, force state=IDLE, output_valid=0, all counters 0 and (with LBC_STATUS_EN) out_row=0, out_col=0, frame_done=0, asynchronously.
REQ-022 SHALL, after rst release, ignore input_valid until the first sof.

Configuration
REQ-023 SHALL use macro LBC_STATUS_EN: when defined, out_row/out_col update with output_valid and hold otherwise, and frame_done pulses one cycle after entering DONE.
REQ-024 SHALL, without LBC_STATUS_EN, omit those ports and their registers; output_valid timing identical.

Structure
REQ-025 SHALL place the state encoding typedef and a counter-width function in package lbc_pkg.
REQ-026 SHALL implement per-axis counting (position, wrap, stride phase, hit flag) in sub-module lbc_axis_counter, instantiated for column and row.

Verification
REQ-027 SHALL cover INPUT_Y=8, INPUT_X=8, K=3, S=2, continuous valid after sof: 9 output_valid pulses, first one cycle after the 19th accepted pixel, at (row,col) (2,2),(2,4),(2,6),(4,2),...,(6,6).
REQ-028 SHALL cover the same frame with S=1: 36 pulses, one per pixel with r>=2, c>=2.
REQ-029 SHALL cover S=2 with input_valid randomly gapped: pulse count and positions as REQ-027, never asserted after an idle cycle.
REQ-030 SHALL cover sof reasserted after 30 pixels: no pulse from the aborted frame, the restarted frame produces exactly 9 pulses.
REQ-031 SHALL cover rst=0 asserted mid-ACTIVE: output_valid low immediately, and input_valid ignored until the next sof.
REQ-032 SHALL, with LBC_STATUS_EN, check a frame_done pulse one cycle after pixel (7,7) and that extra pixels in DONE give no pulses.
